// File: rtl/xor_descrambler_pkg.sv
// Shared types and constants for the XOR descrambler: state encoding,
// default keystream seed/taps and the Galois LFSR step function.
package xor_descrambler_pkg;

   localparam int unsigned LFSR_W = 16;

   localparam logic [LFSR_W-1:0] DEF_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] DEF_TAPS = 16'hB400;

   typedef enum logic [0:0] {
      UNSYNC = 1'b0,
      RUN    = 1'b1
   } state_e;

   // One Galois step: shift right, fold taps back in when the LSB falls out.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
      return (s >> 1) ^ (s[0] ? taps : LFSR_W'(0));
   endfunction

endpackage

// File: rtl/xor_descrambler_lfsr.sv
// 16-bit Galois LFSR keystream generator with load, advance and hold.
module xor_descrambler_lfsr
   import xor_descrambler_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEF_SEED,
   parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              advance,
   output logic [LFSR_W-1:0] key
);

   // Load wins over advance; neither asserted holds the current keystream word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key <= SEED;
      end else if (load) begin
         key <= load_val;
      end else if (advance) begin
         key <= lfsr_next(key, TAPS);
      end
   end

endmodule

// File: rtl/xor_descrambler.sv
// Streaming 16-bit XOR descrambler with valid/ready on both sides.
// Optional payload word counter port enabled by defining XOR_DESCRAMBLER_CNT_EN.
module xor_descrambler
   import xor_descrambler_pkg::*;
#(
   parameter int unsigned       WIDTH = LFSR_W,
   parameter logic [WIDTH-1:0]  SEED  = DEF_SEED,
   parameter logic [WIDTH-1:0]  TAPS  = DEF_TAPS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sync,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef XOR_DESCRAMBLER_CNT_EN
   output logic [15:0]      word_cnt,
`endif
   output logic             locked
);

   localparam logic [0:0] ST_UNSYNC = UNSYNC;
   localparam logic [0:0] ST_RUN    = RUN;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             accept;
   logic             sync_acc;
   logic             pay_acc;
   logic             run;
   logic             lfsr_adv;
   logic [WIDTH-1:0] seed_val;
   logic [WIDTH-1:0] key;

   assign in_ready = !out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign sync_acc = accept & in_sync;
   assign pay_acc  = accept & !in_sync;
   assign run      = (state == ST_RUN);
   assign locked   = run;
   assign lfsr_adv = pay_acc & run;

   // A zero seed would lock the LFSR at zero, so fall back to the default.
   assign seed_val = (in_data == '0) ? SEED : in_data;

   xor_descrambler_lfsr #(
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sync_acc),
      .load_val (seed_val),
      .advance  (lfsr_adv),
      .key      (key)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_UNSYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_UNSYNC: if (sync_acc) state_nxt = ST_RUN;
         ST_RUN:    state_nxt = ST_RUN;
         default:   state_nxt = ST_UNSYNC;
      endcase
   end

   // Output holding register; a new payload word overrides consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (lfsr_adv) begin
         out_valid <= 1'b1;
         out_data  <= in_data ^ key;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef XOR_DESCRAMBLER_CNT_EN
   // Emitted-word count since the last sync; a sync clears even on a consume cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= 16'h0000;
      end else if (sync_acc) begin
         word_cnt <= 16'h0000;
      end else if (out_valid && out_ready) begin
         word_cnt <= word_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// Scoreboard bench for xor_descrambler: directed vectors, queue-based output monitor.
module tb_xor_descrambler;

   typedef struct {
      logic [15:0] data;
      int          cyc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_sync;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        locked;
`ifdef XOR_DESCRAMBLER_CNT_EN
   logic [15:0] word_cnt;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];

   xor_descrambler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sync   (in_sync),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef XOR_DESCRAMBLER_CNT_EN
      .word_cnt  (word_cnt),
`endif
      .locked    (locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pops expected words whenever the DUT hands one over.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out: got %h expected no output", out_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_data !== e.data) begin
               failures++;
               $display("FAIL out_data: got %h expected %h", out_data, e.data);
            end else if (e.lat && cyc != e.cyc) begin
               failures++;
               $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
            end
         end
      end
   end

   // Drive one word; push expectation if it should produce output.
   task automatic send(input logic [15:0] d, input logic s, input bit push,
                       input logic [15:0] exp_d, input bit lat);
      int n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_sync  = s;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      if (push) begin
         e.data = exp_d;
         e.cyc  = cyc;
         e.lat  = lat;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_sync   = 1'b0;
      out_ready = 1'b1;
      #23;
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_locked", 16'(locked), 16'h0);
      rst_n = 1'b1;

      // Payload without sync is dropped.
      send(16'h1234, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(2);
      check("unsync_out_valid", 16'(out_valid), 16'h0);
      check("unsync_locked", 16'(locked), 16'h0);
      check("unsync_in_ready", 16'(in_ready), 16'h1);

      // Sync ACE1 then back-to-back payloads.
      send(16'hACE1, 1'b1, 1'b0, 16'h0, 1'b0);
      #2;
      check("locked_after_sync", 16'(locked), 16'h1);
      send(16'h0000, 1'b0, 1'b1, 16'hACE1, 1'b1);
      send(16'hFFFF, 1'b0, 1'b1, 16'h1D8F, 1'b1);
      send(16'h0000, 1'b0, 1'b1, 16'h7138, 1'b1);
      idle(3);

      // Zero sync word substitutes the seed.
      send(16'h0000, 1'b1, 1'b0, 16'h0, 1'b0);
      send(16'h0000, 1'b0, 1'b1, 16'hACE1, 1'b1);
      idle(3);

      // Backpressure holds data and the keystream.
      send(16'hACE1, 1'b1, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h0000, 1'b0, 1'b1, 16'hACE1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("bp_out_valid", 16'(out_valid), 16'h1);
         check("bp_out_data", out_data, 16'hACE1);
         check("bp_in_ready", 16'(in_ready), 16'h0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      send(16'h0000, 1'b0, 1'b1, 16'hE270, 1'b1);
      idle(3);

      // Mid-stream resync.
      send(16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0);
      send(16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b1);
      idle(3);
`ifdef XOR_DESCRAMBLER_CNT_EN
      check("word_cnt", word_cnt, 16'h0001);
`endif
      send(16'h1234, 1'b0, 1'b1, 16'hF943, 1'b1);
      idle(3);
      check("locked_run", 16'(locked), 16'h1);

      // Async reset with a pending word.
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h0000, 1'b0, 1'b0, 16'h0, 1'b0);
      idle(1);
      check("pre_rst_out_valid", 16'(out_valid), 16'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 16'(out_valid), 16'h0);
      check("async_rst_locked", 16'(locked), 16'h0);
      check("async_rst_out_data", out_data, 16'h0000);
      @(negedge clk);
      out_ready = 1'b1;
      rst_n     = 1'b1;
      idle(2);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
